narrow_store: RTL and testbench
===============================

NARROW_STORE -- requirements
Module: narrow_store

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req_valid  input  1  store request present.
REQ-004 SHALL have port: req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-005 SHALL have port: req_addr  input  32  byte address of the store.
REQ-006 SHALL have port: req_data  input  32  register value; only the low bytes selected by req_size are used.
REQ-007 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port: mem_we  output  1  word-write strobe, held until mem_ack.
REQ-009 SHALL have port: mem_addr  output  32  word-aligned address; bits [1:0] are always 0.
REQ-010 SHALL have port: mem_wdata  output  32  lane-positioned write data.
REQ-011 SHALL have port: mem_be  output  4  byte enables; bit i enables mem_wdata[8i+7:8i].
REQ-012 SHALL have port: mem_ack  input  1  memory accepted the current write; ignored while mem_we is 0.
REQ-013 SHALL have port: done  output  1  one-cycle pulse after the final write is acknowledged.
REQ-014 SHALL have port: err  output  1  one-cycle pulse when a request with reserved size is accepted.

Function
REQ-015 SHALL accept a request on any cycle where req_valid and req_ready are both 1, and SHALL capture addr, data and size in that cycle.
REQ-016 SHALL implement FSM states IDLE, FIRST, SECOND and ERR.
REQ-017 SHALL compute off = addr[1:0], mask = 0x1/0x3/0xF for byte/half/word, be8 = mask << off (8 bits), and data64 = zero-extended masked data << (8*off).
REQ-018 SHALL transition IDLE->FIRST on accept; from the next cycle drive mem_we=1, mem_addr={addr[31:2],2'b00}, mem_be=be8[3:0], mem_wdata=data64[31:0].
REQ-019 SHALL hold all mem_* outputs stable in FIRST/SECOND until mem_ack=1.
REQ-020 SHALL, on the FIRST ack, go to SECOND if be8[7:4]!=0, else go to IDLE and pulse done on the following cycle.
REQ-021 SHALL drive in SECOND mem_addr = first address + 4 (modulo 2^32, wrapping 0xFFFFFFFC->0x00000000), mem_be=be8[7:4], mem_wdata=data64[63:32]; on ack go to IDLE and pulse done.
REQ-022 SHALL, for req_size=11, go IDLE->ERR with no memory write, pulse err for one cycle in ERR, then return to IDLE; done SHALL NOT assert.
REQ-023 SHALL drive mem_we=0, mem_be=0 and mem_wdata=0 whenever it is not in FIRST or SECOND.
REQ-024 SHALL allow a new accept in the same cycle done is high, since req_ready=1 in IDLE.
REQ-025 SHALL treat an ack arriving in the first cycle of a write state as valid, giving a minimum latency of 2 cycles from accept to done for aligned stores and 3 cycles for split stores.

Reset
REQ-026 SHALL, with reset high at a clock edge, force state IDLE, req_ready=1, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, done=0 and err=0, including mid-transaction.
REQ-027 SHALL abandon an interrupted store without any completion pulse.

Structure
REQ-028 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and FSM state constants in a shared package with the CPU's other control encodings.
REQ-029 SHALL isolate the mask/shift computation (be8, data64) in one combinational sub-module named store_lane_align; the FSM stays in narrow_store.

Verification
REQ-030 SHALL check: byte store addr 0x00000013, data 0xAABBCCDD, ack immediate -> one write addr 0x10, be 1000, wdata 0xDD000000; done 2 cycles after accept.
REQ-031 SHALL check: half store addr 0x00000103, data 0x00001234 -> write 0x100 be 1000 wdata 0x34000000, then 0x104 be 0001 wdata 0x00000012; done once.
REQ-032 SHALL check: word store addr 0xFFFFFFFE, data 0x11223344 -> writes 0xFFFFFFFC be 1100 wdata 0x33440000, then 0x00000000 be 0011 wdata 0x00001122.
REQ-033 SHALL check: mem_ack held low 5 cycles during FIRST -> mem_* stable for those 5 cycles and req_ready=0 throughout.
REQ-034 SHALL check: req_size=11 -> err pulse for 1 cycle, mem_we never high, done never high.
REQ-035 SHALL check: reset asserted during SECOND -> next cycle mem_we=0, req_ready=1, no done; a following aligned word store completes normally.

Source files
------------

// File: rtl/narrow_store_pkg.sv
// Shared control encodings: store sizes and narrow-store FSM states.
package narrow_store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FIRST  = 2'b01,
        SECOND = 2'b10,
        ERR    = 2'b11
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/narrow_store_lane_align.sv
// Positions a byte/half/word store onto byte lanes across two adjacent words.
module store_lane_align
    import narrow_store_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [7:0]  be8,
    output logic [63:0] data64
);

    logic [3:0]  mask;
    logic [31:0] masked;

    // Select the lane mask from the size, then shift mask and data by the byte offset.
    always_comb begin
        mask = '0;
        case (size)
            SZ_BYTE: mask = 4'h1;
            SZ_HALF: mask = 4'h3;
            SZ_WORD: mask = 4'hF;
            default: mask = '0;
        endcase
        masked = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        be8    = {4'b0000, mask} << off;
        data64 = {32'h0000_0000, masked} << {off, 3'b000};
    end

endmodule

// File: rtl/narrow_store.sv
// Narrow store unit: splits unaligned byte/half/word stores into one or two word writes.
module narrow_store
    import narrow_store_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        done,
    output logic        err
);

    state_e      state;
    logic [7:0]  be8;
    logic [63:0] data64;
    logic [3:0]  be_hi;
    logic [31:0] wdata_hi;

    store_lane_align u_align (
        .off    (req_addr[1:0]),
        .data   (req_data),
        .size   (req_size),
        .be8    (be8),
        .data64 (data64)
    );

    // Store FSM; the upper-word half of the aligned store is parked in be_hi/wdata_hi
    // at accept so the outputs only need reloading on the FIRST ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            be_hi     <= '0;
            wdata_hi  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_size == SZ_RSVD) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            state     <= FIRST;
                            mem_we    <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be8[3:0];
                            mem_wdata <= data64[31:0];
                            be_hi     <= be8[7:4];
                            wdata_hi  <= data64[63:32];
                        end
                    end
                end
                FIRST: begin
                    if (mem_ack) begin
                        if (be_hi != '0) begin
                            state     <= SECOND;
                            mem_addr  <= mem_addr + 32'd4;
                            mem_be    <= be_hi;
                            mem_wdata <= wdata_hi;
                        end else begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_be    <= '0;
                            mem_wdata <= '0;
                            done      <= 1'b1;
                        end
                    end
                end
                SECOND: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        done      <= 1'b1;
                    end
                end
                ERR: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_be    <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_narrow_store.sv
// Directed bench for narrow_store: table of stores with immediate ack plus stall, error and reset sequences.
module tb_narrow_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        err;

    int passed = 0;
    int total  = 0;

    narrow_store dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic        split;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " mem_we"},    {31'b0, mem_we},    32'd0);
        chk({tag, " mem_be"},    {28'b0, mem_be},    32'd0);
        chk({tag, " mem_wdata"}, mem_wdata,          32'd0);
        chk({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic check_write(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        chk({tag, " mem_we"},    {31'b0, mem_we},    32'd1);
        chk({tag, " mem_addr"},  mem_addr,           a);
        chk({tag, " mem_be"},    {28'b0, mem_be},    {28'b0, be});
        chk({tag, " mem_wdata"}, mem_wdata,          wd);
        chk({tag, " req_ready"}, {31'b0, req_ready}, 32'd0);
        chk({tag, " done"},      {31'b0, done},      32'd0);
    endtask

    initial begin
        logic [31:0] sa;
        logic [3:0]  sbe;
        logic [31:0] swd;
        int          we_seen;
        int          done_seen;

        vecs[0] = '{32'h0000_0013, 32'hAABB_CCDD, 2'b00, 32'h0000_0010, 4'b1000, 32'hDD00_0000, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[1] = '{32'h0000_0103, 32'h0000_1234, 2'b01, 32'h0000_0100, 4'b1000, 32'h3400_0000, 1'b1, 32'h0000_0104, 4'b0001, 32'h0000_0012};
        vecs[2] = '{32'hFFFF_FFFE, 32'h1122_3344, 2'b10, 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000, 1'b1, 32'h0000_0000, 4'b0011, 32'h0000_1122};
        vecs[3] = '{32'h0000_0200, 32'hDEAD_BEEF, 2'b10, 32'h0000_0200, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[4] = '{32'h0000_0002, 32'hFFFF_5678, 2'b01, 32'h0000_0000, 4'b1100, 32'h5678_0000, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[5] = '{32'h0000_0001, 32'h1234_56A5, 2'b00, 32'h0000_0000, 4'b0010, 32'h0000_A500, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[6] = '{32'h0000_0001, 32'h0000_ABCD, 2'b01, 32'h0000_0000, 4'b0110, 32'h00AB_CD00, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[7] = '{32'h0000_1001, 32'hCAFE_F00D, 2'b10, 32'h0000_1000, 4'b1110, 32'hFEF0_0D00, 1'b1, 32'h0000_1004, 4'b0001, 32'h0000_00CA};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        mem_ack   = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset err", {31'b0, err}, 32'd0);
        reset = 1'b0;
        step();

        // Table: every store acked immediately.
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive_req(vecs[i].addr, vecs[i].data, vecs[i].size);
            mem_ack = 1'b1;
            step();
            req_valid = 1'b0;
            check_write({tag, " first"}, vecs[i].a0, vecs[i].be0, vecs[i].wd0);
            step();
            if (vecs[i].split) begin
                check_write({tag, " second"}, vecs[i].a1, vecs[i].be1, vecs[i].wd1);
                step();
            end
            chk({tag, " done"}, {31'b0, done}, 32'd1);
            check_idle_outputs({tag, " after"});
            mem_ack = 1'b0;
            step();
            chk({tag, " done one-shot"}, {31'b0, done}, 32'd0);
        end

        // Stall: ack held low for 5 cycles in FIRST.
        drive_req(32'h0000_0040, 32'h0102_0304, 2'b10);
        mem_ack = 1'b0;
        step();
        req_valid = 1'b0;
        sa = mem_addr; sbe = mem_be; swd = mem_wdata;
        check_write("stall entry", 32'h0000_0040, 4'b1111, 32'h0102_0304);
        for (int c = 0; c < 5; c++) begin
            step();
            if (c < 4) begin
                chk("stall mem_addr", mem_addr, sa);
                chk("stall mem_be", {28'b0, mem_be}, {28'b0, sbe});
                chk("stall mem_wdata", mem_wdata, swd);
                chk("stall mem_we", {31'b0, mem_we}, 32'd1);
                chk("stall req_ready", {31'b0, req_ready}, 32'd0);
            end else begin
                chk("stall held mem_addr", mem_addr, sa);
                chk("stall held req_ready", {31'b0, req_ready}, 32'd0);
                mem_ack = 1'b1;
            end
        end
        step();
        mem_ack = 1'b0;
        chk("stall done", {31'b0, done}, 32'd1);

        // Back-to-back: new request accepted in the done cycle.
        drive_req(32'h0000_0080, 32'h5555_AAAA, 2'b10);
        step();
        req_valid = 1'b0;
        check_write("b2b second store", 32'h0000_0080, 4'b1111, 32'h5555_AAAA);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("b2b done", {31'b0, done}, 32'd1);
        step();

        // Reserved size: err pulse only.
        we_seen = 0;
        done_seen = 0;
        drive_req(32'h0000_0010, 32'hFFFF_FFFF, 2'b11);
        mem_ack = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rsvd err", {31'b0, err}, 32'd1);
        chk("rsvd req_ready", {31'b0, req_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            if (mem_we) we_seen++;
            if (done) done_seen++;
            step();
            if (c == 0) begin
                chk("rsvd err one-shot", {31'b0, err}, 32'd0);
                chk("rsvd back to ready", {31'b0, req_ready}, 32'd1);
            end
        end
        chk("rsvd mem_we never", we_seen, 0);
        chk("rsvd done never", done_seen, 0);
        mem_ack = 1'b0;

        // Reset while in SECOND.
        drive_req(32'h0000_0103, 32'h0000_1234, 2'b01);
        mem_ack = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check_write("rst-mid second", 32'h0000_0104, 4'b0001, 32'h0000_0012);
        mem_ack = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_outputs("rst-mid");
        chk("rst-mid done", {31'b0, done}, 32'd0);
        chk("rst-mid mem_addr", mem_addr, 32'd0);
        step();
        chk("rst-mid no late done", {31'b0, done}, 32'd0);

        drive_req(32'h0000_0300, 32'h8765_4321, 2'b10);
        mem_ack = 1'b1;
        step();
        req_valid = 1'b0;
        check_write("post-rst", 32'h0000_0300, 4'b1111, 32'h8765_4321);
        step();
        mem_ack = 1'b0;
        chk("post-rst done", {31'b0, done}, 32'd1);
        check_idle_outputs("post-rst after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
